// File: rtl/player_mover_pkg.sv
// Shared types and constants for the player movement slice: FSM encoding,
// screen geometry, player start positions and pacing counter width.
package player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STEP   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam int PLAYER_SIZE = 5;
    localparam int SCREEN_W    = 160;
    localparam int SCREEN_H    = 120;

    localparam int P1_START_X = 20;
    localparam int P1_START_Y = 57;
    localparam int P2_START_X = 134;
    localparam int P2_START_Y = 57;

    localparam int CNT_W = 24;

    // Resolve a pair of opposing requests: {positive, negative}; both or neither cancel.
    function automatic logic [1:0] axis_req(input logic pos, input logic neg);
        return {pos & ~neg, neg & ~pos};
    endfunction

endpackage

// File: rtl/player_mover_if.sv
// Keyboard/collision-facing signal bundle of one player mover.
// The slave side is the mover itself; the master side drives requests and flags.
interface player_mover_if;
    logic       req_right;
    logic       req_left;
    logic       req_up;
    logic       req_down;
    logic       move_right;
    logic       move_left;
    logic       move_up;
    logic       move_down;
    logic [7:0] x;
    logic [6:0] y;
    logic       stepped;
    logic       bumped;

    modport master (
        output req_right, req_left, req_up, req_down,
        output move_right, move_left, move_up, move_down,
        input  x, y, stepped, bumped
    );

    modport slave (
        input  req_right, req_left, req_up, req_down,
        input  move_right, move_left, move_up, move_down,
        output x, y, stepped, bumped
    );
endinterface

// File: rtl/player_mover_step_timer.sv
// Loadable pacing down-counter with zero flag. With PLAYER_MOVER_ACCEL_EN defined,
// a saturating streak of clean steps halves the reload once it reaches 8.
module step_timer
    import player_pkg::*;
#(
    parameter int STEP_DIV = 833333
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       clear,
    input  logic       dec,
    input  logic       idle,
    input  logic       step_eval,
    input  logic       step_ok,
    input  logic       step_bump,
    input  logic [3:0] req_vec,
    output logic       zero
);
    localparam logic [CNT_W-1:0] SLOW_RELOAD = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] reload_value;

`ifdef PLAYER_MOVER_ACCEL_EN
    localparam logic [CNT_W-1:0] FAST_RELOAD = CNT_W'(STEP_DIV / 2 - 1);
    localparam logic [3:0]       STREAK_MAX  = 4'd8;

    logic [3:0] streak_reg;
    logic [3:0] last_req_reg;

    assign reload_value = (streak_reg == STREAK_MAX) ? FAST_RELOAD : SLOW_RELOAD;

    // Request-vector changes are detected at the step that acts on them.
    always_ff @(posedge clock) begin
        if (reset) begin
            streak_reg   <= 4'd0;
            last_req_reg <= 4'd0;
        end else if (idle) begin
            streak_reg   <= 4'd0;
            last_req_reg <= req_vec;
        end else if (step_eval) begin
            last_req_reg <= req_vec;
            if ((req_vec != last_req_reg) || step_bump)
                streak_reg <= 4'd0;
            else if (step_ok && (streak_reg != STREAK_MAX))
                streak_reg <= streak_reg + 4'd1;
        end
    end
`else
    logic unused_streak_inputs;
    assign unused_streak_inputs = ^{idle, step_eval, step_ok, step_bump, req_vec};
    assign reload_value = SLOW_RELOAD;
`endif

    always_ff @(posedge clock) begin
        if (reset)
            count_reg <= '0;
        else if (clear)
            count_reg <= '0;
        else if (load)
            count_reg <= reload_value;
        else if (dec && (count_reg != '0))
            count_reg <= count_reg - CNT_W'(1);
    end

    assign zero = (count_reg == '0);
endmodule

// File: rtl/player_mover.sv
// Per-player movement controller: paced one-pixel steps gated by collision flags
// and screen bounds. Optional acceleration via PLAYER_MOVER_ACCEL_EN (in step_timer).
module player_mover
    import player_pkg::*;
#(
    parameter int STEP_DIV = 833333,
    parameter int START_X  = P1_START_X,
    parameter int START_Y  = P1_START_Y,
    parameter int X_MIN    = 1,
    parameter int X_MAX    = 154,
    parameter int Y_MIN    = 1,
    parameter int Y_MAX    = 114
) (
    input  logic          clock,
    input  logic          reset,
    player_mover_if.slave bus
);
    state_t     state_reg;
    logic [7:0] x_reg;
    logic [6:0] y_reg;
    logic       stepped_reg;
    logic       bumped_reg;
    logic       settle_reg;

    logic [1:0] h_req;
    logic [1:0] v_req;
    logic       want_r, want_l, want_u, want_d;
    logic       can_r, can_l, can_u, can_d;
    logic       any_req, step_ok, step_bump;
    logic       timer_zero, timer_load, timer_clear, timer_dec;

    assign h_req  = axis_req(bus.req_right, bus.req_left);
    assign v_req  = axis_req(bus.req_down, bus.req_up);
    assign want_r = h_req[1];
    assign want_l = h_req[0];
    assign want_d = v_req[1];
    assign want_u = v_req[0];
    assign any_req = |{h_req, v_req};

    // Bounds are checked before the +/-1 so the position can never wrap.
    assign can_r = bus.move_right && (x_reg < 8'(X_MAX));
    assign can_l = bus.move_left  && (x_reg > 8'(X_MIN));
    assign can_u = bus.move_up    && (y_reg > 7'(Y_MIN));
    assign can_d = bus.move_down  && (y_reg < 7'(Y_MAX));

    assign step_ok   = (want_r & can_r) | (want_l & can_l) | (want_u & can_u) | (want_d & can_d);
    assign step_bump = (want_r & ~can_r) | (want_l & ~can_l) | (want_u & ~can_u) | (want_d & ~can_d);

    assign timer_load  = any_req && ((state_reg == ST_IDLE) || ((state_reg == ST_SETTLE) && settle_reg));
    assign timer_clear = (state_reg == ST_WAIT) && !any_req;
    assign timer_dec   = (state_reg == ST_WAIT) && any_req;

    step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .clock     (clock),
        .reset     (reset),
        .load      (timer_load),
        .clear     (timer_clear),
        .dec       (timer_dec),
        .idle      (state_reg == ST_IDLE),
        .step_eval (state_reg == ST_STEP),
        .step_ok   (step_ok),
        .step_bump (step_bump),
        .req_vec   ({bus.req_right, bus.req_left, bus.req_up, bus.req_down}),
        .zero      (timer_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            x_reg       <= 8'(START_X);
            y_reg       <= 7'(START_Y);
            stepped_reg <= 1'b0;
            bumped_reg  <= 1'b0;
            settle_reg  <= 1'b0;
        end else begin
            stepped_reg <= 1'b0;
            bumped_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (any_req)
                        state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!any_req)
                        state_reg <= ST_IDLE;
                    else if (timer_zero)
                        state_reg <= ST_STEP;
                end
                ST_STEP: begin
                    if (want_r && can_r)
                        x_reg <= x_reg + 8'd1;
                    else if (want_l && can_l)
                        x_reg <= x_reg - 8'd1;
                    if (want_d && can_d)
                        y_reg <= y_reg + 7'd1;
                    else if (want_u && can_u)
                        y_reg <= y_reg - 7'd1;
                    stepped_reg <= step_ok;
                    bumped_reg  <= step_bump;
                    settle_reg  <= 1'b0;
                    state_reg   <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // Two cycles so the registered collision flags catch up with x/y.
                    if (!settle_reg) begin
                        settle_reg <= 1'b1;
                    end else begin
                        settle_reg <= 1'b0;
                        state_reg  <= any_req ? ST_WAIT : ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.x       = x_reg;
    assign bus.y       = y_reg;
    assign bus.stepped = stepped_reg;
    assign bus.bumped  = bumped_reg;
endmodule

// File: tb/tb_player_mover.sv
// Randomized bench for player_mover: held-request segments with per-cycle random
// collision flags, checked against a step-schedule model of position and pulses.
module tb_player_mover;
    localparam int STEP_DIV = 4;
    localparam int START_X  = 20;
    localparam int START_Y  = 57;
    localparam int X_MIN    = 1;
    localparam int X_MAX    = 154;
    localparam int Y_MIN    = 1;
    localparam int Y_MAX    = 114;
`ifdef PLAYER_MOVER_ACCEL_EN
    localparam int ACCEL = 1;
`else
    localparam int ACCEL = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    player_mover_if bus ();

    player_mover #(
        .STEP_DIV (STEP_DIV),
        .START_X  (START_X),
        .START_Y  (START_Y),
        .X_MIN    (X_MIN),
        .X_MAX    (X_MAX),
        .Y_MIN    (Y_MIN),
        .Y_MAX    (Y_MAX)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int mx;
    int my;

    task automatic check_value(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input logic [3:0] rv);
        bus.req_right = rv[3];
        bus.req_left  = rv[2];
        bus.req_up    = rv[1];
        bus.req_down  = rv[0];
    endtask

    // Flags are mostly permissive so bounds get reached in long segments.
    task automatic randomize_flags();
        bus.move_right = ($urandom_range(0, 3) != 0);
        bus.move_left  = ($urandom_range(0, 3) != 0);
        bus.move_up    = ($urandom_range(0, 3) != 0);
        bus.move_down  = ($urandom_range(0, 3) != 0);
    endtask

    task automatic check_outputs(input int exp_st, input int exp_bu);
        check_value("x", int'(bus.x), mx);
        check_value("y", int'(bus.y), my);
        check_value("stepped", int'(bus.stepped), exp_st);
        check_value("bumped", int'(bus.bumped), exp_bu);
    endtask

    // Requests held for edges 1..len starting from IDLE, then released long enough to return to IDLE.
    task automatic run_segment(input logic [3:0] rv, input int len);
        int  next_step;
        int  streak;
        int  nsteps;
        int  nbumps;
        int  nx;
        int  ny;
        int  st;
        int  bu;
        bit  hr, hl, vu, vd;
        hr = rv[3] & ~rv[2];
        hl = rv[2] & ~rv[3];
        vu = rv[1] & ~rv[0];
        vd = rv[0] & ~rv[1];
        next_step = STEP_DIV + 2;
        streak = 0;
        nsteps = 0;
        nbumps = 0;
        set_req(rv);
        randomize_flags();
        for (int e = 1; e <= len + STEP_DIV + 6; e++) begin
            @(posedge clock);
            st = 0;
            bu = 0;
            if ((hr | hl | vu | vd) && (e <= len) && (e == next_step)) begin
                nx = mx;
                ny = my;
                if (hr) begin
                    if (bus.move_right && mx < X_MAX) nx = mx + 1; else bu = 1;
                end
                if (hl) begin
                    if (bus.move_left && mx > X_MIN) nx = mx - 1; else bu = 1;
                end
                if (vu) begin
                    if (bus.move_up && my > Y_MIN) ny = my - 1; else bu = 1;
                end
                if (vd) begin
                    if (bus.move_down && my < Y_MAX) ny = my + 1; else bu = 1;
                end
                st = ((nx != mx) || (ny != my)) ? 1 : 0;
                mx = nx;
                my = ny;
                nsteps += st;
                nbumps += bu;
                if (bu != 0) streak = 0;
                else if (st != 0 && streak < 8) streak++;
                next_step = e + ((ACCEL != 0 && streak == 8) ? (STEP_DIV / 2 + 3) : (STEP_DIV + 3));
            end
            #1;
            check_outputs(st, bu);
            randomize_flags();
            if (e == len) set_req(4'b0000);
        end
        $display("seg req=%b len=%0d steps=%0d bumps=%0d x=%0d y=%0d", rv, len, nsteps, nbumps, mx, my);
    endtask

    task automatic reset_midway(input logic [3:0] rv, input int k);
        set_req(rv);
        repeat (k) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        mx = START_X;
        my = START_Y;
        check_outputs(0, 0);
        reset = 1'b0;
        set_req(4'b0000);
        $display("reset req=%b after=%0d x=%0d y=%0d", rv, k, mx, my);
    endtask

    initial begin
        set_req(4'b0000);
        randomize_flags();
        reset = 1'b1;
        mx = START_X;
        my = START_Y;
        repeat (2) @(posedge clock);
        #1;
        check_outputs(0, 0);
        $display("reset x=%0d y=%0d", mx, my);
        reset = 1'b0;

        run_segment(4'b1000, 20);
        run_segment(4'b1100, 30);
        run_segment(4'b0001, 3);
        run_segment(4'b1010, 40);
        run_segment(4'b1000, 1700);
        run_segment(4'b0110, 1900);
        reset_midway(4'b1000, 6);
        reset_midway(4'b0101, 9);
        for (int i = 0; i < 40; i++)
            run_segment(4'($urandom_range(0, 15)), int'($urandom_range(1, 60)));
        run_segment(4'b0001, 120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/player_mover.md
# player_mover

Per-player movement controller converting held direction requests into paced one-pixel position steps. Consumes the four `move_*` permission flags from the player collision block and produces the registered `x`/`y` position that feeds back into collision and into the VGA draw path. Paces steps with a programmable divider and inserts settle cycles so the registered collision flags always reflect the current position before the next step.

## Interface
- `STEP_DIV`, 833333: clock cycles waited in WAIT before each step; legal range 2 to 2^24-1.
- `START_X`, 20: reset x position.
- `START_Y`, 57: reset y position.
- `X_MIN`, 1: lowest legal x.
- `X_MAX`, 154: highest legal x.
- `Y_MIN`, 1: lowest legal y.
- `Y_MAX`, 114: highest legal y.
- `clock` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_right`, `req_left`, `req_up`, `req_down` in 1 each: held direction requests from the keyboard decoder.
- `move_right`, `move_left`, `move_up`, `move_down` in 1 each: permission flags from collision; 1 = step allowed.
- `x` out 8: player x position.
- `y` out 7: player y position.
- `stepped` out 1: one-cycle pulse when `x` or `y` changed on this edge.
- `bumped` out 1: one-cycle pulse when a requested axis step was refused by a flag or a bound.

## Operation
- States: IDLE, WAIT, STEP, SETTLE.
- Reset: `x`=START_X, `y`=START_Y, `stepped`=0, `bumped`=0, state IDLE, counter 0, streak 0. Reset takes priority over every other input.
- Effective horizontal request: exactly one of `req_right`/`req_left` is high. Both high or both low means no horizontal request. Vertical requests are resolved the same way from `req_up`/`req_down`.
- IDLE: if any effective request is present, go to WAIT and load the counter with STEP_DIV-1.
- WAIT: decrement the counter. If the effective request disappears, go to IDLE and clear the counter. When the counter is 0, go to STEP.
- STEP: the axes are evaluated independently, so diagonal steps are legal.
  - Right: x+1 if `move_right` and x<X_MAX.
  - Left: x-1 if `move_left` and x>X_MIN.
  - Up: y-1 if `move_up` and y>Y_MIN.
  - Down: y+1 if `move_down` and y<Y_MAX.
  - Any change sets `stepped`=1. Any requested axis refused sets `bumped`=1. Both may pulse on the same edge.
  - Next state is SETTLE.
- SETTLE: lasts 2 cycles, because collision flags are registered one cycle behind the position. Then go to WAIT (reloading the counter) if a request is still present, else IDLE.
- Arithmetic: `x`/`y` never wrap. The bounds are checked before the ±1 is applied, so underflow past 0 and overflow past 255/127 cannot occur.

## Timing
- A request sampled in IDLE on edge 1 produces its first position update on edge STEP_DIV+2.
- Steady-state step period while held is STEP_DIV+3 cycles.
- Flags and requests are sampled only in the STEP cycle. Flag changes in other states have no effect.
- `stepped`/`bumped` are registered and high for exactly the cycle following STEP.
- Reset in any state returns to IDLE with the start position on the next edge.

## Configuration
- `PLAYER_MOVER_ACCEL_EN` defined:
  - A streak counter (saturating at 8) counts consecutive successful steps with an unchanged request vector.
  - At streak 8, WAIT loads STEP_DIV/2-1 (integer divide) instead of STEP_DIV-1.
  - The streak clears on IDLE, on any request-vector change, or on a step with `bumped`=1.
- Undefined: fixed pacing; no streak logic is synthesized.

## Structure
- Package `player_pkg` holds:
  - state encoding typedef;
  - `PLAYER_SIZE`=5;
  - screen bounds 160x120;
  - default start positions for both players;
  - counter width constant (24).
- Sub-module `step_timer`: loadable down-counter with a zero flag. Owns the STEP_DIV reload logic and, under `PLAYER_MOVER_ACCEL_EN`, the streak counter.

## Test plan
- Reset with STEP_DIV=4, START_X=20, START_Y=57 → x=20, y=57, `stepped`=0.
- `req_right` held, all flags 1 → x=21 on edge 6, x=22 on edge 13, `stepped` pulses every 7 cycles.
- x=154, `req_right` held → x stays 154, `bumped` pulses every 7 cycles, `stepped` stays 0.
- `req_right`+`req_up`, `move_up`=0 → x increments, y unchanged, `stepped` and `bumped` both pulse.
- `req_left`+`req_right` both held → stays in IDLE, no pulses. `req_down` dropped mid-WAIT → IDLE, y unchanged.
- `PLAYER_MOVER_ACCEL_EN`, STEP_DIV=4, `req_down` held → first 8 steps at 7-cycle period, then a 5-cycle period; a blocked step restores the 7-cycle period.
